// File: rtl/opcode_locator_pipe.sv
`default_nettype none
// ============================================================================
// Module      : opcode_locator_pipe
// Description : Locates the opcode inside an x86 instruction window (first
//               non-prefix byte, 0F escape, malformed-window faults) and
//               returns the result through a 2-entry skid-buffered
//               valid/ready pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
module opcode_locator_pipe #(
    parameter int WINDOW_BYTES = 8,
    parameter int MAX_PREFIX   = 4,
    parameter int SEL_W        = $clog2(WINDOW_BYTES)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [8*WINDOW_BYTES-1:0] in_bytes,
    input  logic [WINDOW_BYTES-1:0]   in_is_prefix,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_opcode_sel,
    output logic                      out_opcode_size,
    output logic [15:0]               out_opcode,
    output logic                      out_fault,
    output logic [1:0]                out_fault_code
);

    localparam logic [SEL_W-1:0] c_LAST_SEL   = SEL_W'(WINDOW_BYTES - 1);
    localparam logic [1:0]       c_FLT_NONE   = 2'd0;
    localparam logic [1:0]       c_FLT_PREFIX = 2'd1;
    localparam logic [1:0]       c_FLT_NOOP   = 2'd2;
    localparam logic [1:0]       c_FLT_TRUNC  = 2'd3;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic             size;
        logic [15:0]      opcode;
        logic [1:0]       code;
    } entry_t;

    logic             w_found;
    logic [SEL_W-1:0] w_p;
    logic [7:0]       w_b0;
    logic [7:0]       w_b1;
    entry_t           w_new;
    logic             w_accept;
    logic             w_drain;

    entry_t           r_main;
    entry_t           r_skid;
    logic             r_main_valid;
    logic             r_skid_valid;

    // Find the first non-prefix byte and pick out it and its successor.
    always_comb begin
        w_found = 1'b0;
        w_p     = '0;
        // Scanning downward leaves the lowest non-prefix index in w_p,
        // so prefix flags above the opcode have no effect.
        for (int k = WINDOW_BYTES - 1; k >= 0; k--) begin
            if (!in_is_prefix[k]) begin
                w_found = 1'b1;
                w_p     = SEL_W'(k);
            end
        end
        w_b0 = 8'h00;
        w_b1 = 8'h00;
        for (int k = 0; k < WINDOW_BYTES; k++) begin
            if (SEL_W'(k) == w_p) begin
                w_b0 = in_bytes[8*k +: 8];
            end
            if ((k > 0) && (SEL_W'(k - 1) == w_p)) begin
                w_b1 = in_bytes[8*k +: 8];
            end
        end
    end

    // Classify the window; fault priority is no-opcode, overflow, truncation.
    always_comb begin
        w_new = '0;
        if (!w_found) begin
            w_new.code = c_FLT_NOOP;
            w_new.sel  = c_LAST_SEL;
        end else begin
            w_new.sel = w_p;
            if (int'(w_p) > MAX_PREFIX) begin
                w_new.code   = c_FLT_PREFIX;
                w_new.opcode = {8'h00, w_b0};
            end else if (w_b0 == 8'h0F) begin
                if (w_p == c_LAST_SEL) begin
                    // Escape byte with no room for its second byte.
                    w_new.code   = c_FLT_TRUNC;
                    w_new.opcode = 16'h000F;
                end else begin
                    w_new.size   = 1'b1;
                    w_new.opcode = {w_b1, 8'h0F};
                end
            end else begin
                w_new.code   = c_FLT_NONE;
                w_new.opcode = {8'h00, w_b0};
            end
        end
    end

    // in_ready is the registered "skid empty" flag, so no path from out_ready.
    assign in_ready = ~r_skid_valid;
    assign w_accept = in_valid & ~r_skid_valid;
    assign w_drain  = r_main_valid & out_ready;

    // Two-entry skid buffer: main drives the outputs, skid absorbs one extra.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_drain && r_skid_valid) begin
            // in_ready is low here, so no accept can coincide.
            r_main       <= r_skid;
            r_skid_valid <= 1'b0;
        end else if (w_accept && (!r_main_valid || w_drain)) begin
            r_main       <= w_new;
            r_main_valid <= 1'b1;
        end else if (w_accept) begin
            r_skid       <= w_new;
            r_skid_valid <= 1'b1;
        end else if (w_drain) begin
            r_main_valid <= 1'b0;
        end
    end

    assign out_valid       = r_main_valid;
    assign out_opcode_sel  = r_main.sel;
    assign out_opcode_size = r_main.size;
    assign out_opcode      = r_main.opcode;
    assign out_fault_code  = r_main.code;
    assign out_fault       = (r_main.code != c_FLT_NONE);

endmodule
`default_nettype wire

// File: tb/tb_opcode_locator_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_opcode_locator_pipe
// Description : Scoreboard bench for opcode_locator_pipe: directed vectors,
//               backpressure, flush and reset cases, then random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_opcode_locator_pipe;

    localparam int WB   = 8;
    localparam int SW   = 3;
    localparam int MAXP = 4;

    typedef struct packed {
        logic [SW-1:0] sel;
        logic          size;
        logic [15:0]   op;
        logic [1:0]    code;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, flush, in_valid, out_ready;
    logic [8*WB-1:0] in_bytes;
    logic [WB-1:0] in_is_prefix;
    logic          in_ready, out_valid, out_opcode_size, out_fault;
    logic [SW-1:0] out_opcode_sel;
    logic [15:0]   out_opcode;
    logic [1:0]    out_fault_code;

    logic          s7_in_ready, s7_out_valid, s7_size, s7_fault;
    logic [SW-1:0] s7_sel;
    logic [15:0]   s7_op;
    logic [1:0]    s7_code;
    logic          s7_out_ready = 1'b1;

    opcode_locator_pipe #(.WINDOW_BYTES(WB), .MAX_PREFIX(MAXP)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_bytes(in_bytes), .in_is_prefix(in_is_prefix),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode_sel(out_opcode_sel), .out_opcode_size(out_opcode_size),
        .out_opcode(out_opcode), .out_fault(out_fault),
        .out_fault_code(out_fault_code)
    );

    opcode_locator_pipe #(.WINDOW_BYTES(WB), .MAX_PREFIX(7)) dut7 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s7_in_ready),
        .in_bytes(in_bytes), .in_is_prefix(in_is_prefix),
        .out_valid(s7_out_valid), .out_ready(s7_out_ready),
        .out_opcode_sel(s7_sel), .out_opcode_size(s7_size),
        .out_opcode(s7_op), .out_fault(s7_fault),
        .out_fault_code(s7_code)
    );

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: walk the window as a byte array and apply the rules directly.
    function automatic exp_t model(input logic [8*WB-1:0] b, input logic [WB-1:0] pf, input int maxp);
        exp_t e;
        int   p;
        logic [7:0] win [WB];
        for (int k = 0; k < WB; k++) win[k] = b[8*k +: 8];
        p = 0;
        while (p < WB && pf[p]) p++;
        e = '0;
        if (p == WB) begin
            e.code = 2'd2;
            e.sel  = SW'(WB - 1);
        end else begin
            e.sel = SW'(p);
            if (p > maxp) begin
                e.code = 2'd1;
                e.op   = {8'h00, win[p]};
            end else if (win[p] == 8'h0F) begin
                if (p == WB - 1) begin
                    e.code = 2'd3;
                    e.op   = 16'h000F;
                end else begin
                    e.size = 1'b1;
                    e.op   = {win[p+1], 8'h0F};
                end
            end else begin
                e.op = {8'h00, win[p]};
            end
        end
        return e;
    endfunction

    // Record what the DUT will accept at the coming edge, then advance.
    task automatic cyc();
        if (reset || flush) q.delete();
        else if (in_valid && in_ready) q.push_back(model(in_bytes, in_is_prefix, MAXP));
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        exp_t hv;
        logic held;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (held) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'({out_opcode_sel, out_opcode_size, out_opcode, out_fault_code}), 32'(hv));
            end
            held = 1'b0;
            if (out_valid && !out_ready && !flush && !reset) begin
                held = 1'b1;
                hv   = {out_opcode_sel, out_opcode_size, out_opcode, out_fault_code};
            end
            if (out_valid && out_ready && !flush && !reset) begin
                chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("sb_sel", 32'(out_opcode_sel), 32'(e.sel));
                    chk("sb_size", 32'(out_opcode_size), 32'(e.size));
                    chk("sb_opcode", 32'(out_opcode), 32'(e.op));
                    chk("sb_code", 32'(out_fault_code), 32'(e.code));
                    chk("sb_fault", 32'(out_fault), 32'(e.code != 2'd0));
                end
            end
        end
    endtask

    task automatic rand_bytes();
        for (int k = 0; k < WB; k++) in_bytes[8*k +: 8] = 8'($urandom);
    endtask

    task automatic rand_window();
        int n;
        rand_bytes();
        in_is_prefix = WB'($urandom);
        n = $urandom_range(0, WB);
        for (int k = 0; k < n; k++) in_is_prefix[k] = 1'b1;
        if (n < WB) begin
            in_is_prefix[n] = 1'b0;
            if ($urandom_range(0, 2) == 0) in_bytes[8*n +: 8] = 8'h0F;
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_fields"}, 32'({out_opcode_sel, out_opcode_size, out_opcode, out_fault, out_fault_code}), 32'd0);
    endtask

    exp_t e1, e2, e3;
    int   guard;

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_bytes = '0; in_is_prefix = '0;
        fork
            monitor();
        join_none
        @(posedge clk); #1;
        cyc(); cyc();
        chk_reset_state("rst");
        reset = 1'b0;
        cyc();

        // Plain one-byte opcode
        out_ready = 1'b1;
        rand_bytes(); in_bytes[7:0] = 8'h89; in_is_prefix = 8'h00; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("plain_latency", 32'(out_valid), 32'd1);
        chk("plain_sel", 32'(out_opcode_sel), 32'd0);
        chk("plain_size", 32'(out_opcode_size), 32'd0);
        chk("plain_op", 32'(out_opcode), 32'h0089);
        chk("plain_fault", 32'(out_fault), 32'd0);
        cyc();

        // Two prefixes then a 0F escape
        in_bytes = 64'h1122_3344_B80F_F366; in_is_prefix = 8'b0000_0011; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("esc_sel", 32'(out_opcode_sel), 32'd2);
        chk("esc_size", 32'(out_opcode_size), 32'd1);
        chk("esc_op", 32'(out_opcode), 32'hB80F);
        chk("esc_fault", 32'(out_fault), 32'd0);
        cyc();

        // All prefixes: no opcode
        rand_bytes(); in_is_prefix = 8'hFF; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("noop_code", 32'(out_fault_code), 32'd2);
        chk("noop_sel", 32'(out_opcode_sel), 32'd7);
        chk("noop_fault", 32'(out_fault), 32'd1);
        cyc();

        // Five prefixes exceed MAX_PREFIX=4
        rand_bytes(); in_bytes[47:40] = 8'h90; in_is_prefix = 8'b0001_1111; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("ovf_code", 32'(out_fault_code), 32'd1);
        chk("ovf_sel", 32'(out_opcode_sel), 32'd5);
        chk("ovf_op", 32'(out_opcode), 32'h0090);
        cyc();

        // Escape in the last byte: truncated on the MAX_PREFIX=7 instance
        rand_bytes(); in_bytes[63:56] = 8'h0F; in_is_prefix = 8'b0111_1111; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("trunc_code", 32'(s7_code), 32'd3);
        chk("trunc_op", 32'(s7_op), 32'h000F);
        chk("trunc_size", 32'(s7_size), 32'd0);
        chk("trunc_fault", 32'(s7_fault), 32'd1);
        chk("trunc_main_code", 32'(out_fault_code), 32'd1);
        cyc();

        // Backpressure: three windows offered, two fit
        out_ready = 1'b0; in_valid = 1'b1; in_is_prefix = 8'h00;
        rand_bytes(); in_bytes[7:0] = 8'h11; e1 = model(in_bytes, in_is_prefix, MAXP);
        cyc();
        chk("bp_latency", 32'(out_valid), 32'd1);
        rand_bytes(); in_bytes[7:0] = 8'h22; e2 = model(in_bytes, in_is_prefix, MAXP);
        cyc();
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        rand_bytes(); in_bytes[7:0] = 8'h33; e3 = model(in_bytes, in_is_prefix, MAXP);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_op", 32'(out_opcode), 32'(e1.op));
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        chk("bp_second", 32'(out_opcode), 32'(e2.op));
        cyc();
        in_valid = 1'b0;
        chk("bp_third", 32'(out_opcode), 32'(e3.op));
        cyc();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Flush with both entries full and a window on the input
        out_ready = 1'b0; in_valid = 1'b1;
        rand_window(); cyc();
        rand_window(); cyc();
        rand_window(); flush = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        // Flush while in_ready is high: the offered window must be dropped
        in_valid = 1'b1; rand_window(); cyc();
        rand_window(); flush = 1'b1; cyc();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        chk("flush2_valid", 32'(out_valid), 32'd0);

        // Reset while an output is stalled
        out_ready = 1'b0; in_valid = 1'b1; rand_window(); cyc();
        in_valid = 1'b0; reset = 1'b1;
        cyc();
        chk_reset_state("midrst");
        reset = 1'b0; in_valid = 1'b1; rand_window();
        e1 = model(in_bytes, in_is_prefix, MAXP);
        cyc();
        in_valid = 1'b0;
        chk("postrst_latency", 32'(out_valid), 32'd1);
        chk("postrst_op", 32'(out_opcode), 32'(e1.op));
        out_ready = 1'b1;
        cyc();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            if (flush) out_ready = 1'b0;
            rand_window();
            cyc();
        end

        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        guard = 0;
        while ((q.size() != 0 || out_valid) && guard < 20) begin
            cyc();
            guard++;
        end
        chk("drain_left", 32'(q.size()), 32'd0);
        chk("drain_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
